// File: rtl/down_counter_if.sv
// down_counter bus: load/enable controls in, count and status out.
// Master drives controls, the counter is the slave.
interface down_counter_if #(
  parameter int WIDTH = 8
);
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             Enable;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Zero;
  logic             Done;

  modport master (
    output Load,
    output LoadValue,
    output Enable,
    input  Q,
    input  Busy,
    input  Zero,
    input  Done
  );

  modport slave (
    input  Load,
    input  LoadValue,
    input  Enable,
    output Q,
    output Busy,
    output Zero,
    output Done
  );
endinterface

// File: rtl/down_counter.sv
// Loadable, enable-gated down counter/timer with one-cycle Done
// strobe at terminal count and optional auto-reload.
module down_counter #(
  parameter int WIDTH       = 8,
  parameter int AUTO_RELOAD = 0
) (
  input  logic          Clock,
  input  logic          Reset,
  down_counter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] NULL = '0;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;

  logic load_w;
  logic step_w;

  assign load_w = bus.Load;
  assign step_w = !bus.Load && (state_q == RUN)
                && bus.Enable;

  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    state_d  = state_q;
    done_d   = 1'b0;
    unique case (1'b1)
      load_w: begin
        reload_d = bus.LoadValue;
        q_d      = bus.LoadValue;
        state_d  = (bus.LoadValue != NULL) ? RUN
                                           : IDLE;
      end
      step_w: begin
        if (q_q == ONE) begin
          done_d = 1'b1;
          if (AUTO_RELOAD != 0) begin
            q_d     = reload_q;
            state_d = RUN;
          end else begin
            q_d     = NULL;
            state_d = IDLE;
          end
        end else begin
          q_d = q_q - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q      <= NULL;
      reload_q <= NULL;
      state_q  <= IDLE;
      done_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      done_q   <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Busy = (state_q == RUN);
  assign bus.Zero = (q_q == NULL);
  assign bus.Done = done_q;

  a_reset: assert property (
    @(posedge Clock)
    Reset |=> q_q == NULL && !done_q
          && state_q == IDLE);

  a_hold: assert property (
    @(posedge Clock) disable iff (Reset)
    state_q == RUN && !bus.Load && !bus.Enable
      |=> q_q == $past(q_q));

  a_count: assert property (
    @(posedge Clock) disable iff (Reset)
    state_q == RUN && !bus.Load && bus.Enable
      && q_q > ONE
      |=> q_q == $past(q_q) - ONE);

  // A reload value of 1 legitimately strobes Done every cycle
  a_done: assert property (
    @(posedge Clock) disable iff (Reset)
    done_q && !step_w |=> !done_q);

  a_idle: assert property (
    @(posedge Clock) disable iff (Reset)
    state_q == IDLE && !bus.Load
      |=> q_q == NULL);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench: directed vector table, auto-reload sequence
// and randomized traffic checked against a behavioural model.
module tb_down_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  down_counter_if #(.WIDTH(8)) if0 ();
  down_counter_if #(.WIDTH(8)) if1 ();

  down_counter #(.WIDTH(8), .AUTO_RELOAD(0)) dut0 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if0)
  );

  down_counter #(.WIDTH(8), .AUTO_RELOAD(1)) dut1 (
    .Clock (clk),
    .Reset (rst),
    .bus   (if1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model per instance: index 0 stops, index 1 reloads
  int mq[2];
  int mrel[2];
  bit mrun[2];
  bit mdone[2];

  typedef struct {
    bit       r;
    bit       l;
    bit [7:0] v;
    bit       e;
    bit [7:0] q;
    bit       busy;
    bit       done;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic void model(input int k,
      input bit r, input bit l,
      input int v, input bit e);
    if (r) begin
      mq[k] = 0; mrel[k] = 0;
      mrun[k] = 0; mdone[k] = 0;
    end else if (l) begin
      mrel[k] = v; mq[k] = v;
      mrun[k] = (v != 0); mdone[k] = 0;
    end else if (mrun[k] && e) begin
      mq[k] = mq[k] - 1;
      mdone[k] = (mq[k] == 0);
      if (mq[k] == 0) begin
        if (k == 1) mq[k] = mrel[k];
        else mrun[k] = 0;
      end
    end else begin
      mdone[k] = 0;
    end
  endfunction

  task automatic step(input bit r, input bit l,
      input bit [7:0] v, input bit e);
    rst = r;
    if0.Load = l; if0.LoadValue = v; if0.Enable = e;
    if1.Load = l; if1.LoadValue = v; if1.Enable = e;
    @(posedge clk);
    model(0, r, l, int'(v), e);
    model(1, r, l, int'(v), e);
    #1;
    chk("m0_q",    int'(if0.Q),    mq[0]);
    chk("m0_busy", int'(if0.Busy), int'(mrun[0]));
    chk("m0_done", int'(if0.Done), int'(mdone[0]));
    chk("m0_zero", int'(if0.Zero), int'(mq[0] == 0));
    chk("m1_q",    int'(if1.Q),    mq[1]);
    chk("m1_busy", int'(if1.Busy), int'(mrun[1]));
    chk("m1_done", int'(if1.Done), int'(mdone[1]));
    chk("m1_zero", int'(if1.Zero), int'(mq[1] == 0));
  endtask

  function automatic void add(bit r, bit l,
      bit [7:0] v, bit e,
      bit [7:0] q, bit b, bit d);
    vec_t t;
    t.r = r; t.l = l; t.v = v; t.e = e;
    t.q = q; t.busy = b; t.done = d;
    vt.push_back(t);
  endfunction

  initial begin
    bit [7:0] rv;
    rst = 1'b1;
    if0.Load = 1'b1; if0.LoadValue = 8'h10;
    if0.Enable = 1'b0;
    if1.Load = 1'b1; if1.LoadValue = 8'h10;
    if1.Enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mrel[k] = 0;
      mrun[k] = 0; mdone[k] = 0;
    end

    // reset with load pending
    add(1, 1, 8'h10, 0, 0, 0, 0);
    add(1, 1, 8'h10, 0, 0, 0, 0);
    // basic count 3,2,1,0 then no wrap
    add(0, 1, 3, 0, 3, 1, 0);
    add(0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    // pause at 3
    add(0, 1, 5, 0, 5, 1, 0);
    add(0, 0, 0, 1, 4, 1, 0);
    add(0, 0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1);
    // load beats enable; load of zero
    add(0, 1, 7, 0, 7, 1, 0);
    add(0, 1, 2, 1, 2, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].l, vt[i].v, vt[i].e);
      chk($sformatf("vec%0d_q", i),
          int'(if0.Q), int'(vt[i].q));
      chk($sformatf("vec%0d_busy", i),
          int'(if0.Busy), int'(vt[i].busy));
      chk($sformatf("vec%0d_done", i),
          int'(if0.Done), int'(vt[i].done));
    end

    // reset mid-count from 8'hFF
    step(0, 1, 8'hFF, 1);
    chk("ff_load", int'(if0.Q), 255);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("ff_cnt", int'(if0.Q), 245);
    step(1, 0, 0, 1);
    chk("mid_rst_q0", int'(if0.Q), 0);
    chk("mid_rst_q1", int'(if1.Q), 0);
    chk("mid_rst_b1", int'(if1.Busy), 0);
    step(0, 0, 0, 1);
    chk("post_rst_q1", int'(if1.Q), 0);
    chk("post_rst_z1", int'(if1.Zero), 1);

    // auto-reload period 4
    step(0, 1, 4, 1);
    chk("ar_load", int'(if1.Q), 4);
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 0, 1);
      chk($sformatf("ar_q%0d", k),
          int'(if1.Q), 4 - (k % 4));
      chk($sformatf("ar_done%0d", k),
          int'(if1.Done), int'(k % 4 == 0));
      chk($sformatf("ar_busy%0d", k),
          int'(if1.Busy), 1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: rv = 8'd0;
        1: rv = 8'd1;
        2: rv = 8'($urandom_range(2, 6));
        default: rv = 8'($urandom_range(0, 255));
      endcase
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 9) == 0,
           rv,
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable, enable-gated down counter/timer; the decrementing counterpart to the team's 8-bit up counter. Software or a controlling FSM loads a start value, then each enabled cycle counts toward zero. Reaching zero raises a one-cycle `Done` strobe and either stops or reloads the last loaded value. The block carries embedded concurrent assertions (reset, hold, count, done) in the same style as the up counter.

## Interface
- `WIDTH`, 8, counter width in bits
- `AUTO_RELOAD`, 0, 1 = on terminal count reload the last loaded value and keep running; 0 = stop at zero
- `Clock` in 1: sole clock, all logic on rising edge
- `Reset` in 1: synchronous, active-high; sampled on `posedge Clock` only
- `Load` in 1: load `LoadValue` into counter this cycle
- `LoadValue` in WIDTH: start/reload value
- `Enable` in 1: decrement permission for this cycle
- `Q` out WIDTH: current count, registered
- `Busy` out 1: high in state RUN, registered
- `Zero` out 1: `Q == 0`, combinational from `Q`
- `Done` out 1: one-cycle terminal-count strobe, registered

## Operation
- State machine, 2 states: IDLE (count not armed), RUN (counting).
- Internal register `ReloadReg` (WIDTH) captures `LoadValue` on every accepted `Load`.
- Priority per cycle: `Reset` > `Load` > `Enable` > hold.
- `Reset`: `Q`=0, `ReloadReg`=0, state IDLE, `Done`=0, `Busy`=0.
- `Load` with `LoadValue != 0` (any state): `Q`=`LoadValue`, state RUN, `Done`=0. `Enable` in the same cycle is ignored, with no decrement.
- `Load` with `LoadValue == 0` (any state): `Q`=0, state IDLE, `Done`=0. No terminal-count event.
- RUN, `Enable`=1, `Q > 1`: `Q`=`Q-1`.
- RUN, `Enable`=1, `Q == 1` (terminal): `Done`=1 next cycle.
  - `AUTO_RELOAD`=0: `Q`=0, state IDLE.
  - `AUTO_RELOAD`=1: `Q`=`ReloadReg`, state remains RUN. `Q` never shows 0 in this case.
- RUN, `Enable`=0: `Q` holds, state holds.
- IDLE, `Enable`=1: no effect. `Q` stays 0 and never wraps to all-ones.
- `Done` is high for exactly one cycle per terminal event and is otherwise 0.

## Timing
- All outputs except `Zero` update on the `posedge Clock` following the sampled inputs, with 1-cycle latency.
- Load to first decrement: `Load` at edge N, earliest decrement at edge N+1.
- Loading value V with `Enable` held high: `Done` asserts V cycles after the load edge. For `AUTO_RELOAD`=1 the period is V cycles.
- `Reset` asserted mid-count takes effect at the next edge regardless of `Load`/`Enable`. `Reset` between edges has no effect, because reset is synchronous.
- Arithmetic is modulo 2^WIDTH, but the decrement is never applied at `Q`=0, so no underflow path exists.
- Required embedded assertions:
  - `Reset |=> Q==0 && !Done && !Busy`
  - disable iff (`Reset`): `Busy && !Load && !Enable |=> Q==$past(Q)`
  - `Busy && !Load && Enable && Q>1 |=> Q==$past(Q)-1`
  - `Done |=> !Done`
  - `!Busy && !Load |=> Q==0`

## Test plan
- Reset: drive `Reset`=1 for 2 cycles with `Load`=1, `LoadValue`=8'h10 -> `Q`=0, `Busy`=0, `Done`=0 after the first edge. No load is taken.
- Basic count: `Load` 8'd3, then `Enable`=1 -> `Q` 3,2,1,0. `Done`=1 only in the cycle `Q` first reads 0. `Busy` falls with it. `Q` stays 0 for 3 further enabled cycles, with no wrap to 8'hFF.
- Pause: `Load` 8'd5, enable 2 cycles, drop `Enable` 4 cycles, re-enable -> `Q` holds at 3 while disabled. `Done` appears 3 enabled cycles after resume.
- Load precedence: during RUN at `Q`=7, assert `Load`=1, `LoadValue`=8'd2, `Enable`=1 -> next `Q`=2, not 6 or 1. Separately, `Load` 8'd0 while running -> `Q`=0, IDLE, `Done` stays 0.
- Auto-reload (`AUTO_RELOAD`=1): `Load` 8'd4, `Enable` held -> sequence 4,3,2,1,4,3,… `Done` pulses every 4 cycles, coinciding with `Q` returning to 4. `Busy` stays 1.
- Reset mid-operation: `Load` 8'hFF, count 10 cycles, pulse `Reset` 1 cycle -> `Q`=0, IDLE, `ReloadReg` cleared. A subsequent `Enable` leaves `Q`=0. No assertion fires throughout.
